// File: rtl/counter_responder.sv
// Four-counter event bank answering single-beat memory reads/writes with a 1-cycle response.
// Optional CNT_CLEAR_ON_READ_EN: a mapped read clears the selected counter.
//   state | meaning
//   IDLE  | waiting for mem_read/mem_write
//   RESP  | mem_resp asserted, new requests ignored
module counter_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  evt,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q [4];
  logic [31:0] cnt_d [4];
  logic [31:0] rdata_q, rdata_d;
  logic        sample;
  logic        hit;
  logic [1:0]  sel;
  logic        wr_take;
  logic        rd_take;
  logic        unused_addr_lsb;

  assign hit             = (mem_address[31:4] == BASE_ADDR[31:4]);
  assign sel             = mem_address[3:2];
  assign unused_addr_lsb = ^mem_address[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    mem_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = RESP;
          sample  = 1'b1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        mem_resp = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous read+write is treated as a write only.
  assign wr_take = sample && mem_write;
  assign rd_take = sample && mem_read && !mem_write;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + {31'b0, evt[i]};
      if (wr_take && hit && (sel == 2'(i))) begin
        cnt_d[i] = mem_wdata;
      end
`ifdef CNT_CLEAR_ON_READ_EN
      else if (rd_take && hit && (sel == 2'(i))) begin
        cnt_d[i] = {31'b0, evt[i]};
      end
`endif
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_take) begin
      rdata_d = hit ? cnt_q[sel] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 32'h0;
      end
      rdata_q <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;

endmodule
